// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution accumulate/schedule path.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ROUND,
        ST_OUTPUT
    } state_t;

    localparam int SUM_W  = 21;
    localparam int ACC_W  = 25;
    localparam int OUT_W  = 8;
    localparam int MAX_CH = 16;

endpackage

// File: rtl/acc_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of an accumulator.
// Optional ReLU clamp when CONV_ACC_RELU_EN is defined.
module acc_round_sat #(
    parameter int ACC_W = conv_pkg::ACC_W,
    parameter int OUT_W = conv_pkg::OUT_W
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [4:0]       shift,
    output logic signed [OUT_W-1:0] res
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

    // One extra bit of headroom so adding the rounding half never wraps.
    function automatic logic signed [ACC_W:0] round_shift(
        input logic signed [ACC_W-1:0] a,
        input logic        [4:0]       sh
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] half;
        ext = {a[ACC_W-1], a};
        if (sh == 5'd0) begin
            return ext;
        end
        half = (ACC_W+1)'(1) << (sh - 5'd1);
        return (ext + half) >>> sh;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] r);
        if (r > SAT_HI) begin
            return SAT_HI[OUT_W-1:0];
        end
        if (r < SAT_LO) begin
            return SAT_LO[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
`ifdef CONV_ACC_RELU_EN
        return v[OUT_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign res = relu(saturate(round_shift(acc, shift)));

endmodule

// File: rtl/conv3x3_acc_sched.sv
// Channel sequencer and cross-channel accumulator feeding the output activation stream.
// Build option CONV_ACC_RELU_EN (in acc_round_sat) clamps negative activations to zero.
module conv3x3_acc_sched #(
    parameter int SUM_W = conv_pkg::SUM_W,
    parameter int ACC_W = conv_pkg::ACC_W,
    parameter int OUT_W = conv_pkg::OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic        [3:0]       cfg_nch_m1,
    input  logic        [15:0]      cfg_npix_m1,
    input  logic        [4:0]       cfg_shift,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [SUM_W-1:0] in_sum,
    output logic        [3:0]       ch_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    busy,
    output logic                    done
);
    import conv_pkg::*;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic        [15:0]      pix_cnt;
    logic        [3:0]       nch_m1;
    logic        [15:0]      npix_m1;
    logic        [4:0]       shift;
    logic signed [OUT_W-1:0] rsat;
    logic                    last_ch;
    logic                    last_pix;

    assign last_ch  = (ch_idx == nch_m1);
    assign last_pix = (pix_cnt == npix_m1);

    acc_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_round (
        .acc   (acc),
        .shift (shift),
        .res   (rsat)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cfg_start) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_ch) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done      = last_pix;
                    state_nxt = last_pix ? ST_IDLE : ST_ACCUM;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            ch_idx   <= '0;
            pix_cnt  <= '0;
            nch_m1   <= '0;
            npix_m1  <= '0;
            shift    <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        nch_m1  <= cfg_nch_m1;
                        npix_m1 <= cfg_npix_m1;
                        shift   <= (cfg_shift > 5'd24) ? 5'd24 : cfg_shift;
                        acc     <= '0;
                        ch_idx  <= '0;
                        pix_cnt <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + {{(ACC_W-SUM_W){in_sum[SUM_W-1]}}, in_sum};
                        if (!last_ch) ch_idx <= ch_idx + 4'd1;
                    end
                end
                ST_ROUND: begin
                    out_data <= rsat;
                end
                ST_OUTPUT: begin
                    // Next pixel restarts the channel sweep from a clean accumulator.
                    if (out_ready && !last_pix) begin
                        pix_cnt <= pix_cnt + 16'd1;
                        acc     <= '0;
                        ch_idx  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
